// File: rtl/led_status_pkg.sv
// Shared types and constants for the status-code LED blinker.
//   state_t   : sequencer states
//   DEF_*     : default parameter values
//   cnt_width : width of a tick counter that must reach max(on, off, gap)
package led_status_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        ON,
        OFF,
        GAP
    } state_t;

    localparam int DEF_CODE_W    = 4;
    localparam int DEF_ON_TICKS  = 1;
    localparam int DEF_OFF_TICKS = 1;
    localparam int DEF_GAP_TICKS = 4;

    function automatic int cnt_width(input int on_t, input int off_t, input int gap_t);
        int m;
        m = on_t;
        if (off_t > m) m = off_t;
        if (gap_t > m) m = gap_t;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/hb_edge_detect.sv
// Heartbeat edge detector: produces a one-cycle registered strobe on every
// rising and falling edge of the heartbeat level. Reusable by any heartbeat
// consumer.
//   clk, rst_n : clock, asynchronous active-low reset
//   hb_in      : heartbeat level (clk domain)
//   tick       : one-cycle strobe, one cycle after each hb_in transition
module hb_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic hb_in,
    output logic tick
);

    logic hb_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_d <= 1'b0;
            tick <= 1'b0;
        end else begin
            hb_d <= hb_in;
            tick <= hb_in ^ hb_d;
        end
    end

endmodule

// File: rtl/led_status_blinker.sv
// Status-code LED sequencer. Shows an accepted code as that many blinks on
// the heartbeat time base, then a dark gap, then returns to IDLE.
//   clk, rst_n         : clock, asynchronous active-low reset
//   hb_in              : heartbeat level; each transition is one tick
//   abort              : forces return to IDLE on the next edge
//   code_valid, code   : code offer
//   code_ready         : high in IDLE while abort is low
//   led                : registered LED drive, active high
//   busy               : high whenever not in IDLE
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a code; ticks ignored
// ARM   | code latched, waiting for a tick to align the first blink
// ON    | LED lit, counting ON_TICKS ticks
// OFF   | LED dark between blinks, counting OFF_TICKS ticks
// GAP   | LED dark after the last blink, counting GAP_TICKS ticks
module led_status_blinker
    import led_status_pkg::*;
#(
    parameter int CODE_W    = DEF_CODE_W,
    parameter int ON_TICKS  = DEF_ON_TICKS,
    parameter int OFF_TICKS = DEF_OFF_TICKS,
    parameter int GAP_TICKS = DEF_GAP_TICKS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hb_in,
    input  logic              abort,
    input  logic              code_valid,
    input  logic [CODE_W-1:0] code,
    output logic              code_ready,
    output logic              led,
    output logic              busy
);

    localparam int CNT_W = cnt_width(ON_TICKS, OFF_TICKS, GAP_TICKS);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [CODE_W-1:0] remaining, remaining_nxt;
    logic [CODE_W-1:0] remaining_dec;
    logic              tick;

    hb_edge_detect u_hb_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .hb_in (hb_in),
        .tick  (tick)
    );

    assign code_ready    = (state == IDLE) && !abort;
    assign busy          = (state != IDLE);
    assign remaining_dec = remaining - CODE_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            remaining <= '0;
            led       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            remaining <= remaining_nxt;
            led       <= (state_nxt == ON);
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        remaining_nxt = remaining;

        if (abort) begin
            state_nxt     = IDLE;
            remaining_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (code_valid) begin
                        remaining_nxt = code;
                        state_nxt     = ARM;
                    end
                end
                ARM: begin
                    if (tick) state_nxt = (remaining != '0) ? ON : GAP;
                end
                ON: begin
                    if (tick) begin
                        if (cnt == CNT_W'(ON_TICKS - 1)) state_nxt = OFF;
                        else                             cnt_nxt   = cnt + CNT_W'(1);
                    end
                end
                OFF: begin
                    if (tick) begin
                        if (cnt == CNT_W'(OFF_TICKS - 1)) begin
                            remaining_nxt = remaining_dec;
                            state_nxt     = (remaining_dec == '0) ? GAP : ON;
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (cnt == CNT_W'(GAP_TICKS - 1)) state_nxt = IDLE;
                        else                              cnt_nxt   = cnt + CNT_W'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        // Every state change starts the new state with a fresh count, so the
        // tick that caused the transition is never counted again.
        if (state_nxt != state) cnt_nxt = '0;
    end

endmodule

// File: tb/tb_led_status_blinker.sv
module tb_led_status_blinker;

    localparam int ON_T  = 1;
    localparam int OFF_T = 1;
    localparam int GAP_T = 4;
    localparam int LIM   = 4000;

    logic       clk;
    logic       rst_n;
    logic       hb_in;
    logic       abort;
    logic       code_valid;
    logic [3:0] code;
    logic       code_ready;
    logic       led;
    logic       busy;

    led_status_blinker #(
        .CODE_W    (4),
        .ON_TICKS  (ON_T),
        .OFF_TICKS (OFF_T),
        .GAP_TICKS (GAP_T)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hb_in      (hb_in),
        .abort      (abort),
        .code_valid (code_valid),
        .code       (code),
        .code_ready (code_ready),
        .led        (led),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit led;
        bit busy;
        bit rdy;
    } exp_t;

    exp_t q[$];
    int   n_err    = 0;
    int   n_checks = 0;

    // Reference model: sequence position measured in ticks since acceptance.
    bit m_busy;
    bit m_led;
    int m_code;
    int m_t;
    int m_total;
    int m_acc = 0;
    bit tick_next;
    bit hb_last;
    bit hb_level = 1'b1;
    int hb_period = 8;
    int hb_cnt = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_err++;
        $display("FAIL timeout %s at %0t: model busy=%0d accepts=%0d", name, $time, m_busy, m_acc);
    endtask

    // LED level after t ticks of a sequence for code c: first tick arms,
    // then c periods of ON_T lit + OFF_T dark ticks, then the gap.
    function automatic bit led_at(input int t, input int c);
        int p;
        p = ON_T + OFF_T;
        return (t >= 1) && ((t - 1) < c * p) && (((t - 1) % p) < ON_T);
    endfunction

    task automatic step(input bit ab, input bit cv, input logic [3:0] cd);
        bit   tick_c;
        exp_t e;
        @(posedge clk);
        #1;
        hb_cnt++;
        if (hb_cnt >= hb_period) begin
            hb_level = ~hb_level;
            hb_cnt   = 0;
        end
        hb_in      = hb_level;
        abort      = ab;
        code_valid = cv;
        code       = cd;

        tick_c = tick_next;
        e.led  = m_led;
        e.busy = m_busy;
        e.rdy  = !m_busy && !ab;
        q.push_back(e);

        tick_next = (hb_level != hb_last);
        hb_last   = hb_level;

        if (ab) begin
            m_busy = 1'b0;
            m_led  = 1'b0;
        end else if (!m_busy) begin
            if (cv) begin
                m_busy  = 1'b1;
                m_led   = 1'b0;
                m_code  = int'(cd);
                m_t     = 0;
                m_total = 1 + m_code * (ON_T + OFF_T) + GAP_T;
                m_acc++;
            end
        end else if (tick_c) begin
            m_t++;
            if (m_t == m_total) begin
                m_busy = 1'b0;
                m_led  = 1'b0;
            end else begin
                m_led = led_at(m_t, m_code);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        abort      = 1'b0;
        code_valid = 1'b0;
        code       = 4'd0;
        rst_n      = 1'b0;
        #1;
        chk("rst_led", led, 0);
        chk("rst_busy", busy, 0);
        chk("rst_code_ready", code_ready, 1);
        repeat (3) begin
            @(posedge clk);
            #1;
            hb_level = ~hb_level;
            hb_in    = hb_level;
        end
        chk("rst_hold_led", led, 0);
        q.delete();
        @(posedge clk);
        #1;
        hb_level = 1'b1;
        hb_in    = 1'b1;
        hb_cnt   = 0;
        rst_n    = 1'b1;
        m_busy    = 1'b0;
        m_led     = 1'b0;
        tick_next = hb_level;
        hb_last   = hb_level;
    endtask

    task automatic offer(input logic [3:0] cd);
        int a0;
        a0 = m_acc;
        for (int i = 0; i < LIM && m_acc == a0; i++) step(1'b0, 1'b1, cd);
        if (m_acc == a0) timeout("accept");
    endtask

    task automatic drain();
        for (int i = 0; i < LIM && m_busy; i++) step(1'b0, 1'b0, 4'd0);
        if (m_busy) timeout("idle");
    endtask

    task automatic wait_led_on();
        for (int i = 0; i < LIM && !m_led; i++) step(1'b0, 1'b0, 4'd0);
        if (!m_led) timeout("led_on");
    endtask

    // Monitor: compares DUT outputs against the queued expectation each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("led", led, e.led);
                chk("busy", busy, e.busy);
                chk("code_ready", code_ready, e.rdy);
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        hb_in      = 1'b1;
        abort      = 1'b0;
        code_valid = 1'b0;
        code       = 4'd0;

        do_reset();
        repeat (6) step(1'b0, 1'b0, 4'd0);

        hb_period = 8;
        offer(4'd3);
        drain();
        repeat (5) step(1'b0, 1'b0, 4'd0);

        offer(4'd0);
        drain();

        offer(4'd15);
        drain();

        offer(4'd5);
        offer(4'd2);
        drain();

        offer(4'd6);
        wait_led_on();
        repeat (3) step(1'b1, 1'b1, 4'd7);
        repeat (6) step(1'b0, 1'b0, 4'd0);

        offer(4'd4);
        wait_led_on();
        do_reset();
        repeat (4) step(1'b0, 1'b0, 4'd0);

        for (int r = 0; r < 4; r++) begin
            hb_period = $urandom_range(1, 6);
            repeat (600)
                step($urandom_range(0, 79) == 0, $urandom_range(0, 3) == 0,
                     4'($urandom_range(0, 15)));
        end
        drain();

        @(negedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
